// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the combinational alu: fetches operands from a
// 16-entry register file, drives the alu, and retires the result or compare flag.
module alu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [15:0]           instr,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cmp_flag,
  output logic                  done,
  output logic                  illegal,
  output logic                  cmp_flag_q,
  input  logic [3:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

  state_t                state, next_state;
  instr_t                instr_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] res_q;
  logic                  flag_q;
  logic                  is_wr_c, is_cmp_c, is_addi_c;

  // R0 is hardwired to zero regardless of array contents
  function automatic logic [DATA_WIDTH-1:0] rd_reg(input logic [3:0] addr);
    return (addr == 4'd0) ? '0 : regs[addr];
  endfunction

  assign dbg_data = rd_reg(dbg_addr);

  // Opcode decode of the latched instruction
  always_comb begin
    is_wr_c   = 1'b0;
    is_cmp_c  = 1'b0;
    is_addi_c = 1'b0;
    case (instr_q.opcode)
      OP_ADD, OP_SUB, OP_MUL: is_wr_c = 1'b1;
      OP_ADDI: begin
        is_wr_c   = 1'b1;
        is_addi_c = 1'b1;
      end
      OP_CMP:  is_cmp_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (instr_valid && instr_ready) next_state = S_READ;
      S_READ:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WB;
      S_WB:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath, register file and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= '0;
      alu_opcode    <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      res_q         <= '0;
      flag_q        <= 1'b0;
      cmp_flag_q    <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      instr_ready   <= 1'b1;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      instr_ready <= (next_state == S_IDLE);
      done        <= (next_state == S_WB);
      illegal     <= (next_state == S_WB) && !(is_wr_c || is_cmp_c);
      case (state)
        S_IDLE: if (instr_valid && instr_ready) instr_q <= instr_t'(instr);
        S_READ: begin
          alu_opcode    <= instr_q.opcode;
          alu_operand_a <= rd_reg(instr_q.rs);
          alu_operand_b <= is_addi_c ? DATA_WIDTH'(instr_q.rt) : rd_reg(instr_q.rt);
        end
        S_EXEC: begin
          res_q  <= alu_result;
          flag_q <= alu_cmp_flag;
        end
        S_WB: begin
          if (is_wr_c && (instr_q.rd != 4'd0)) regs[instr_q.rd] <= res_q;
          if (is_cmp_c) cmp_flag_q <= flag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural alu stub and a
// register-file model; expected retirements are queued at handshake time.
module tb_alu_issue_ctrl;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [15:0]   instr = '0;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_operand_a, alu_operand_b, alu_result;
  logic          alu_cmp_flag;
  logic          done, illegal, cmp_flag_q;
  logic [3:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  alu_issue_ctrl #(.DATA_WIDTH(DW), .NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_opcode(alu_opcode), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_cmp_flag(alu_cmp_flag),
    .done(done), .illegal(illegal), .cmp_flag_q(cmp_flag_q),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // alu stub: 0 ADD, 1 SUB, 2 MUL, 3 CMP, 4 ADDI
  always_comb begin
    case (alu_opcode)
      4'h0, 4'h4: alu_result = alu_operand_a + alu_operand_b;
      4'h1:       alu_result = alu_operand_a - alu_operand_b;
      4'h2:       alu_result = DW'(alu_operand_a * alu_operand_b);
      default:    alu_result = '0;
    endcase
    alu_cmp_flag = (alu_operand_a < alu_operand_b);
  end

  typedef struct {
    logic [3:0]    op;
    logic [3:0]    rd;
    logic [DW-1:0] a, b, res;
    logic          is_wr, is_cmp, flag, ill;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mregs[16];
  logic          mflag;
  int            checks = 0, passes = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(input string tag, input logic [3:0] ad, input logic [DW-1:0] exp);
    dbg_addr = ad;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    e.op     = ins[15:12];
    e.rd     = ins[11:8];
    e.a      = (ins[7:4] == 4'd0) ? '0 : mregs[ins[7:4]];
    e.b      = (ins[3:0] == 4'd0) ? '0 : mregs[ins[3:0]];
    e.is_wr  = 1'b0;
    e.is_cmp = 1'b0;
    e.ill    = 1'b0;
    e.res    = '0;
    case (e.op)
      4'h0: begin e.res = e.a + e.b; e.is_wr = 1'b1; end
      4'h1: begin e.res = e.a - e.b; e.is_wr = 1'b1; end
      4'h2: begin e.res = DW'(e.a * e.b); e.is_wr = 1'b1; end
      4'h3: e.is_cmp = 1'b1;
      4'h4: begin e.b = DW'(ins[3:0]); e.res = e.a + e.b; e.is_wr = 1'b1; end
      default: e.ill = 1'b1;
    endcase
    e.flag = (e.a < e.b);
    return e;
  endfunction

  function automatic void retire(input exp_t e);
    if (e.is_wr && e.rd != 4'd0) mregs[e.rd] = e.res;
    if (e.is_cmp) mflag = e.flag;
  endfunction

  // One full instruction: handshake, latency/ready/operand checks, retire, writeback
  task automatic issue(input string tag, input logic [15:0] ins);
    exp_t e;
    int   n;
    chk({tag, "_ready_idle"}, 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    sb.push_back(model(ins));
    tick();
    instr_valid = 1'b0;
    n = 1;
    while (!done && n < 8) begin
      chk({tag, "_ready_busy"}, 32'(instr_ready), 32'd0);
      if (n == 2) begin
        e = sb[0];
        chk({tag, "_exec_op"}, 32'(alu_opcode), 32'(e.op));
        chk({tag, "_exec_a"}, 32'(alu_operand_a), 32'(e.a));
        chk({tag, "_exec_b"}, 32'(alu_operand_b), 32'(e.b));
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
      retire(e);
    end
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_cmp_flag"}, 32'(cmp_flag_q), 32'(mflag));
    dchk({tag, "_dbg_rd"}, ins[11:8], (ins[11:8] == 4'd0) ? '0 : mregs[ins[11:8]]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   hs, dn, n;
    logic [DW-1:0] snap [6];
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflag = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_opa", 32'(alu_operand_a), 32'd0);
    chk("rst_opb", 32'(alu_operand_b), 32'd0);
    chk("rst_flag", 32'(cmp_flag_q), 32'd0);
    rst_n = 1'b1;
    tick();

    issue("addi_r1", {4'h4, 4'h1, 4'h0, 4'h7});
    issue("addi_r2", {4'h4, 4'h2, 4'h0, 4'h5});
    dchk("r1_is_7", 4'd1, 16'd7);
    dchk("r2_is_5", 4'd2, 16'd5);

    issue("add_r3", {4'h0, 4'h3, 4'h1, 4'h2});
    issue("sub_r4", {4'h1, 4'h4, 4'h1, 4'h2});
    issue("mul_r5", {4'h2, 4'h5, 4'h1, 4'h2});
    dchk("r3_is_12", 4'd3, 16'd12);
    dchk("r4_is_2", 4'd4, 16'd2);
    dchk("r5_is_35", 4'd5, 16'd35);

    issue("cmp_lt", {4'h3, 4'h0, 4'h2, 4'h1});
    chk("cmp_lt_flag", 32'(cmp_flag_q), 32'd1);
    issue("cmp_ge", {4'h3, 4'h0, 4'h1, 4'h2});
    chk("cmp_ge_flag", 32'(cmp_flag_q), 32'd0);

    issue("addi_r0", {4'h4, 4'h0, 4'h1, 4'hf});
    dchk("r0_is_0", 4'd0, 16'd0);

    for (int i = 1; i < 6; i++) snap[i] = mregs[i];
    issue("illegal_op", {4'hf, 4'h1, 4'h2, 4'h3});
    chk("illegal_flag_kept", 32'(cmp_flag_q), 32'd0);
    for (int i = 1; i < 6; i++) dchk($sformatf("illegal_keep_r%0d", i), 4'(i), snap[i]);
    dchk("illegal_r1_const", 4'd1, 16'd7);

    // Valid held high: re-issue only on IDLE cycles
    instr = {4'h4, 4'h6, 4'h6, 4'h1};
    instr_valid = 1'b1;
    hs = 0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done && sb.size() > 0) begin
        e = sb.pop_front();
        chk("hold_illegal", 32'(illegal), 32'(e.ill));
        retire(e);
        dn++;
      end
      if (instr_ready) begin
        chk("hold_accept_cycle", 32'(i % 4), 32'd0);
        sb.push_back(model(instr));
        hs++;
      end
      tick();
    end
    instr_valid = 1'b0;
    chk("hold_handshakes", 32'(hs), 32'd3);
    chk("hold_retired", 32'(dn), 32'd2);
    dchk("hold_r6_is_2", 4'd6, 16'd2);
    n = 0;
    while (!done && n < 8) begin
      tick();
      n++;
    end
    chk("hold_third_done", 32'(done), 32'd1);
    if (done && sb.size() > 0) retire(sb.pop_front());
    tick();
    dchk("hold_r6_is_3", 4'd6, 16'd3);
    dchk("hold_r6_model", 4'd6, mregs[6]);
    chk("hold_ready", 32'(instr_ready), 32'd1);

    // Reset during EXEC discards the instruction
    instr = {4'h0, 4'h7, 4'h1, 4'h2};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("mid_rst_exec_a", 32'(alu_operand_a), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_opcode", 32'(alu_opcode), 32'd0);
    tick();
    tick();
    chk("mid_rst_done_held", 32'(done), 32'd0);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflag = 1'b0;
    tick();
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_done", 32'(done), 32'd0);
      tick();
    end
    dchk("post_rst_r1", 4'd1, 16'd0);
    dchk("post_rst_r2", 4'd2, 16'd0);
    dchk("post_rst_r7", 4'd7, 16'd0);
    chk("post_rst_flag", 32'(cmp_flag_q), 32'd0);

    // Writes still work after the mid-instruction reset
    issue("post_rst_addi", {4'h4, 4'h7, 4'h0, 4'h9});
    dchk("post_rst_r7_is_9", 4'd7, 16'd9);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
